// File: rtl/stream_rx_packer.sv
// stream_rx_packer: packs BEATS consecutive DATA_W-bit upstream beats into one
// DATA_W*BEATS-bit word with a per-slot keep mask. A beat with last_in closes a
// short word early; its unfilled slots read as zero.
//
// Optional feature: define RX_CHECKSUM_EN to make sum_out the modulo-2^DATA_W
// sum of the beats in the current word. Without it sum_out is tied to 0 and no
// adder exists.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   valid_in, data_in,   upstream beat, its data, and end-of-packet flag
//   last_in
//   ready_out            beat accepted this cycle (combinational)
//   flush                discard the partially packed word, block input
//   valid_out, ready_in  packed word presented / accepted downstream
//   data_out, keep_out   packed word (slot 0 in LSBs) and filled-slot mask
//   sum_out              checksum of the beats in the word
module stream_rx_packer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     last_in,
    output logic                     ready_out,
    input  logic                     flush,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [DATA_W*BEATS-1:0]  data_out,
    output logic [BEATS-1:0]         keep_out,
    output logic [DATA_W-1:0]        sum_out
);

    localparam int unsigned WORD_W = DATA_W * BEATS;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  data_q;
    logic [BEATS-1:0]   keep_q;
`ifdef RX_CHECKSUM_EN
    logic [DATA_W-1:0]  sum_q;
`endif

    // Accept when not flushing and either filling or the held word leaves now.
    assign ready_out = !flush && (!valid_out || ready_in);

    // Packing FSM: FILL accumulates beats, HOLD presents the finished word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
            keep_q <= '0;
`ifdef RX_CHECKSUM_EN
            sum_q  <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (flush) begin
                        cnt    <= '0;
                        data_q <= '0;
                        keep_q <= '0;
`ifdef RX_CHECKSUM_EN
                        sum_q  <= '0;
`endif
                    end else if (valid_in) begin
                        data_q[32'(cnt)*DATA_W +: DATA_W] <= data_in;
                        keep_q[cnt] <= 1'b1;
`ifdef RX_CHECKSUM_EN
                        sum_q <= sum_q + data_in;
`endif
                        if (last_in || cnt == CNT_LAST) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Flush cannot touch a held word; it only blocks input.
                    if (ready_in) begin
                        if (valid_in && !flush) begin
                            // Back-to-back: new beat starts the next word in slot 0.
                            data_q <= WORD_W'(data_in);
                            keep_q <= BEATS'(1);
`ifdef RX_CHECKSUM_EN
                            sum_q  <= data_in;
`endif
                            if (last_in) begin
                                state <= HOLD;
                                cnt   <= '0;
                            end else begin
                                state <= FILL;
                                cnt   <= CNT_W'(1);
                            end
                        end else begin
                            state  <= FILL;
                            cnt    <= '0;
                            data_q <= '0;
                            keep_q <= '0;
`ifdef RX_CHECKSUM_EN
                            sum_q  <= '0;
`endif
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign valid_out = (state == HOLD);
    assign data_out  = data_q;
    assign keep_out  = keep_q;
`ifdef RX_CHECKSUM_EN
    assign sum_out   = sum_q;
`else
    assign sum_out   = '0;
`endif

endmodule
